// File: rtl/hpm_counter_bank_pkg.sv
// Shared types and constants for the hardware performance counter bank.
// Provides the channel index type, default step width and select-width helper.
package hpm_counter_bank_pkg;

    localparam int HPM_SEL_W    = 5;
    localparam int HPM_STEP_W   = 2;
    localparam int HPM_STEP_MAX = (1 << HPM_STEP_W) - 1;

    // Wide enough to index any legal bank (up to 32 channels).
    typedef logic [HPM_SEL_W-1:0] hpm_sel_t;

    function automatic int hpm_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// CSR-side bundle for the counter bank: event inputs, write/read port,
// overflow flags. master = CSR file / driver, slave = counter bank.
interface hpm_counter_bank_if
    import hpm_counter_bank_pkg::*;
#(
    parameter int NUM_COUNTERS = 4,
    parameter int XLEN         = 32,
    parameter int STEP_W       = HPM_STEP_W
);
    localparam int SEL_W = hpm_sel_w(NUM_COUNTERS);

    logic [NUM_COUNTERS-1:0]        increment;
    logic [NUM_COUNTERS*STEP_W-1:0] step;
    logic [NUM_COUNTERS-1:0]        inhibit;
    logic                           wr_en;
    logic [SEL_W-1:0]               wr_sel;
    logic                           wr_hi;
    logic [XLEN-1:0]                wr_data;
    logic                           rd_en;
    logic [SEL_W-1:0]               rd_sel;
    logic                           rd_hi;
    logic [XLEN-1:0]                rd_data;
    logic                           rd_valid;
    logic [NUM_COUNTERS-1:0]        ovf_clear;
    logic [NUM_COUNTERS-1:0]        overflow;

    modport master (
        output increment, step, inhibit,
        output wr_en, wr_sel, wr_hi, wr_data,
        output rd_en, rd_sel, rd_hi, ovf_clear,
        input  rd_data, rd_valid, overflow
    );

    modport slave (
        input  increment, step, inhibit,
        input  wr_en, wr_sel, wr_hi, wr_data,
        input  rd_en, rd_sel, rd_hi, ovf_clear,
        output rd_data, rd_valid, overflow
    );

endinterface

// File: rtl/hpm_counter_bank_slice.sv
// One counter channel: count register, sticky overflow, write/increment
// precedence and half-write merge. Ports: write strobe/half/data, gated
// increment enable with step, overflow clear; count and overflow out.
module hpm_counter_slice #(
    parameter int WIDTH  = 64,
    parameter int XLEN   = 32,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              wr_hi_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic              inc_en_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              ovf_clear_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              overflow_o
);

    localparam int HI_W = WIDTH - XLEN;

    logic [WIDTH-1:0] count_q, count_d, wr_merge;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;
    logic             wr_act;
    logic             carry;

    // A high-half write to a counter with no high half is a no-op.
    assign wr_act = wr_en_i && ((HI_W > 0) || !wr_hi_i);

    generate
        if (HI_W > 0) begin : g_hi
            always_comb begin
                if (wr_hi_i)
                    wr_merge = {wr_data_i[HI_W-1:0], count_q[XLEN-1:0]};
                else
                    wr_merge = {count_q[WIDTH-1:XLEN], wr_data_i};
            end
        end else begin : g_nohi
            always_comb wr_merge = wr_data_i;
        end
    endgenerate

    assign sum   = {1'b0, count_q} + {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign carry = inc_en_i && !wr_act && sum[WIDTH];

    always_comb begin
        count_d = count_q;
        if (wr_act)
            count_d = wr_merge;
        else if (inc_en_i)
            count_d = sum[WIDTH-1:0];
    end

    // Set beats clear so a wrap coinciding with a clear is not lost.
    always_comb begin
        ovf_d = ovf_q;
        if (carry)
            ovf_d = 1'b1;
        else if (ovf_clear_i || wr_act)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NUM_COUNTERS wide event counters behind an XLEN-wide CSR port.
// Ports: clk, rst (async, active-high), bus (slave side of the bank bundle).
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int NUM_COUNTERS = 4,
    parameter int WIDTH        = 64,
    parameter int XLEN         = 32,
    parameter int STEP_W       = HPM_STEP_W
) (
    input  logic               clk,
    input  logic               rst,
    hpm_counter_bank_if.slave  bus
);

    localparam int HI_W = WIDTH - XLEN;

    logic [WIDTH-1:0]        count   [NUM_COUNTERS];
    logic [XLEN-1:0]         lo_word [NUM_COUNTERS];
    logic [XLEN-1:0]         hi_word [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] wr_hit;
    logic [NUM_COUNTERS-1:0] ovf;
    hpm_sel_t                wr_sel_x, rd_sel_x;
    logic [XLEN-1:0]         rd_word;
    logic [XLEN-1:0]         rd_data_q, rd_data_d;
    logic                    rd_valid_q;

    assign wr_sel_x = hpm_sel_t'(bus.wr_sel);
    assign rd_sel_x = hpm_sel_t'(bus.rd_sel);

    // Out-of-range selects match no channel, so such writes are dropped.
    generate
        for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ch
            assign wr_hit[i] = bus.wr_en && (wr_sel_x == hpm_sel_t'(i));

            hpm_counter_slice #(
                .WIDTH  (WIDTH),
                .XLEN   (XLEN),
                .STEP_W (STEP_W)
            ) u_slice (
                .clk         (clk),
                .rst         (rst),
                .wr_en_i     (wr_hit[i]),
                .wr_hi_i     (bus.wr_hi),
                .wr_data_i   (bus.wr_data),
                .inc_en_i    (bus.increment[i] && !bus.inhibit[i]),
                .step_i      (bus.step[i*STEP_W +: STEP_W]),
                .ovf_clear_i (bus.ovf_clear[i]),
                .count_o     (count[i]),
                .overflow_o  (ovf[i])
            );

            assign lo_word[i] = count[i][XLEN-1:0];
            if (HI_W > 0) begin : g_hi
                assign hi_word[i] = XLEN'(count[i][WIDTH-1:XLEN]);
            end else begin : g_nohi
                assign hi_word[i] = '0;
            end
        end
    endgenerate

    // Reads see the pre-update count; unmatched selects yield zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_sel_x == hpm_sel_t'(i))
                rd_word = bus.rd_hi ? hi_word[i] : lo_word[i];
        end
    end

    assign rd_data_d = bus.rd_en ? rd_word : rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.rd_en;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.overflow = ovf;

endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
- Parametrised bank of NUM_COUNTERS event counters, the multi-channel successor to the single program/event counter.
- Each channel supports a per-channel step, an inhibit, and a sticky overflow flag, and is wider than XLEN.
- Counters are written and read through an XLEN-wide, half-selectable CSR-style port.
- Sits beside the CSR file and feeds mcycle/minstret/mhpmcounterN and their high halves.

Parameters:
- NUM_COUNTERS, 4: number of independent counter channels (1..32).
- WIDTH, 64: counter width in bits; XLEN <= WIDTH <= 2*XLEN.
- XLEN, 32: access-port width; matches Types::int32_t.
- STEP_W, 2: width of each per-channel step value (unsigned).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high; clears all state immediately.
- increment  in  NUM_COUNTERS  per-channel count enable.
- step  in  NUM_COUNTERS*STEP_W  per-channel unsigned increment; channel i uses bits [i*STEP_W +: STEP_W].
- inhibit  in  NUM_COUNTERS  per-channel freeze (mcountinhibit); blocks increment only, not writes.
- wr_en  in  1  write strobe.
- wr_sel  in  $clog2(NUM_COUNTERS) (min 1)  target channel.
- wr_hi  in  1  0 = write bits [XLEN-1:0]; 1 = write bits [WIDTH-1:XLEN].
- wr_data  in  XLEN  write value.
- rd_en  in  1  read strobe.
- rd_sel  in  $clog2(NUM_COUNTERS) (min 1)  channel to read.
- rd_hi  in  1  half select for read.
- rd_data  out  XLEN  registered read data.
- rd_valid  out  1  high for exactly one cycle after rd_en.
- ovf_clear  in  NUM_COUNTERS  per-channel clear of the sticky overflow flag.
- overflow  out  NUM_COUNTERS  sticky wrap flags.

Behaviour:
- Reset: while rst=1, every count, overflow, rd_data and rd_valid is 0, asynchronously. Deassertion takes effect at the next posedge.
- Per-channel next-state precedence (channel i):
  1. Write: wr_en and wr_sel==i. Only the selected half is replaced; the other half holds. No increment is applied that cycle.
  2. Increment: increment[i] and not inhibit[i]. count <= (count + zero-extended step[i]) mod 2^WIDTH.
  3. Otherwise: hold.
- step=0 with increment=1: count holds and no overflow is set.
- High half: holds bits [WIDTH-1:XLEN]. Writes use only the low WIDTH-XLEN bits of wr_data. Reads are zero-extended to XLEN.
- WIDTH==XLEN: high-half writes are ignored and high-half reads return 0.
- Overflow: set when an increment carries out of bit WIDTH-1. The flag stays set until cleared.
  - ovf_clear[i] clears it.
  - A write to either half of channel i also clears it.
  - Set and clear in the same cycle: set wins, so the event is not lost.
- Read, 1-cycle latency: on the posedge where rd_en=1, rd_data <= selected half of the pre-update count, and rd_valid <= 1.
  - With rd_en=0: rd_valid <= 0 and rd_data holds.
  - Read and write to the same channel in the same cycle returns the old value.
- Out-of-range selects (NUM_COUNTERS not a power of 2): writes are ignored; reads return 0 with rd_valid=1.
- Channels are fully independent. Write and increment on different channels in the same cycle both take effect.
- Reset mid-operation: an in-flight read is dropped (rd_valid=0) and all counts return to 0.
- No combinational path from inputs to outputs.

Decomposition:
- Types package additions:
  - hpm_sel_t: channel index type.
  - constant HPM_STEP_MAX.
- Sub-module hpm_counter_slice: one channel, holding count, overflow, the precedence logic and the half-write merge. The bank instantiates it NUM_COUNTERS times via generate.
- The bank itself holds the write decoder and the registered read mux.

Test Plan:
- Reset: assert rst mid-count with count=0x0000_0001_0000_0005 -> count, overflow, rd_valid read 0 immediately, without waiting for a clock edge.
- Increment/step:
  - ch0 increment=1, step=3 for 4 cycles from 0 -> reads 12.
  - inhibit[0]=1 for 2 further cycles -> still 12.
  - step=0 -> count holds, no overflow.
- Carry into high half: write low=0xFFFF_FFFE, high=0. Then step=3 -> low=0x0000_0001, high=0x0000_0001, overflow=0.
- Wrap/overflow: write high=low=0xFFFF_FFFF, step=1 -> count 0 and overflow[i]=1.
  - ovf_clear together with another wrap -> flag stays 1.
  - ovf_clear alone -> flag goes 0.
- Write precedence: write low=0x10 while increment=1, step=2 on the same channel -> 0x10, not 0x12. The high half is unchanged.
- Read timing: rd_en on ch2 in the same cycle as a write of 0xAB -> next cycle rd_valid=1 with the old value; a read one cycle later returns 0xAB. rd_sel=5 with NUM_COUNTERS=5 -> rd_data=0.
